// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline definitions for the memory stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    localparam int          DEFAULT_WAIT_CYCLES = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int          WAIT_CNT_W          = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - bus wait-state counter with clear, enable and terminal count
module mem_wait_counter
    import mem_stage_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WAIT_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with wait-state bus FSM
// Optional address fault checking is enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_ENIn,
    input  logic              MEM_R_ENIn,
    input  logic              MEM_W_ENIn,
    input  logic [31:0]       ALU_ResIn,
    input  logic [31:0]       Val_RmIn,
    input  logic [3:0]        DestIn,
    output logic              WB_ENOut,
    output logic              MEM_R_ENOut,
    output logic [31:0]       ALU_ResOut,
    output logic [3:0]        DestOut,
    output logic [31:0]       Mem_ResOut,
    output logic              ready,
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    output logic              mem_err
);

    mem_state_t state, next_state;
    logic       req;
    logic       fault;
    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_tc;

    assign req = MEM_R_ENIn | MEM_W_ENIn;

`ifdef MEM_ADDR_CHECK_EN
    logic [31:0] word_idx;

    assign word_idx = (ALU_ResIn - BASE_ADDR) >> 2;
    assign fault    = (ALU_ResIn < BASE_ADDR) || (ALU_ResIn[1:0] != 2'b00)
                   || ((word_idx >> ADDR_W) != 32'd0);
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && !fault) begin
                    next_state = ST_ACCESS;
                    cnt_clear  = 1'b1;
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    mem_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .enable(cnt_en),
        .tc    (cnt_tc)
    );

    // A faulted request is answered in IDLE so the pipeline never stalls on it.
    assign ready   = ((state == ST_IDLE) && (!req || fault)) || (state == ST_DONE);
    assign mem_err = (state == ST_IDLE) && req && fault;

    assign bus_en    = (state == ST_ACCESS);
    assign bus_we    = MEM_W_ENIn && (state == ST_ACCESS);
    assign bus_addr  = ADDR_W'((ALU_ResIn - BASE_ADDR) >> 2);
    assign bus_wdata = Val_RmIn;

    // A simultaneous read+write is a write, so only pure reads capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Mem_ResOut <= 32'd0;
        end else if ((state == ST_ACCESS) && cnt_tc && MEM_R_ENIn && !MEM_W_ENIn) begin
            Mem_ResOut <= bus_rdata;
        end
    end

    assign WB_ENOut    = WB_ENIn;
    assign MEM_R_ENOut = MEM_R_ENIn;
    assign ALU_ResOut  = ALU_ResIn;
    assign DestOut     = DestIn;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_ENIn, MEM_R_ENIn, MEM_W_ENIn;
    logic [31:0] ALU_ResIn, Val_RmIn;
    logic [3:0]  DestIn;
    logic        WB_ENOut, MEM_R_ENOut;
    logic [31:0] ALU_ResOut;
    logic [3:0]  DestOut;
    logic [31:0] Mem_ResOut;
    logic        ready, bus_en, bus_we;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        mem_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .WB_ENIn    (WB_ENIn),
        .MEM_R_ENIn (MEM_R_ENIn),
        .MEM_W_ENIn (MEM_W_ENIn),
        .ALU_ResIn  (ALU_ResIn),
        .Val_RmIn   (Val_RmIn),
        .DestIn     (DestIn),
        .WB_ENOut   (WB_ENOut),
        .MEM_R_ENOut(MEM_R_ENOut),
        .ALU_ResOut (ALU_ResOut),
        .DestOut    (DestOut),
        .Mem_ResOut (Mem_ResOut),
        .ready      (ready),
        .bus_en     (bus_en),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .mem_err    (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] dest);
        WB_ENIn    = wb;
        MEM_R_ENIn = rd;
        MEM_W_ENIn = wr;
        ALU_ResIn  = addr;
        Val_RmIn   = wdata;
        DestIn     = dest;
    endtask

    // Runs one full access: IDLE (stalled), four ACCESS cycles, one DONE cycle.
    // Entered and left at posedge+1; inputs are held throughout.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [5:0] exp_addr,
                          input logic [31:0] old_mem, input logic [31:0] new_mem);
        drive(rd, rd, wr, addr, wdata, 4'd3);
        bus_rdata = rdata;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("%s ready c%0d", tag, i), 32'(ready), 32'(i == 5));
            check($sformatf("%s bus_en c%0d", tag, i), 32'(bus_en), 32'(i >= 1 && i <= 4));
            check($sformatf("%s bus_we c%0d", tag, i), 32'(bus_we), 32'(wr && i >= 1 && i <= 4));
            check($sformatf("%s mem_err c%0d", tag, i), 32'(mem_err), 32'd0);
            check($sformatf("%s Mem_ResOut c%0d", tag, i), Mem_ResOut, (i == 5) ? new_mem : old_mem);
            if (i == 1) begin
                check({tag, " bus_addr"}, 32'(bus_addr), 32'(exp_addr));
                check({tag, " bus_wdata"}, bus_wdata, wdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus_rdata = 32'd0;
        #12;
        check("reset Mem_ResOut", Mem_ResOut, 32'd0);
        check("reset bus_en", 32'(bus_en), 32'd0);
        check("reset bus_we", 32'(bus_we), 32'd0);
        check("reset ready", 32'(ready), 32'd1);
        check("reset mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Non-memory instruction: pure pass-through, no stall
        drive(1'b1, 1'b0, 1'b0, 32'hCAFE0001, 32'd0, 4'd9);
        #1;
        check("nonmem ALU_ResOut", ALU_ResOut, 32'hCAFE0001);
        check("nonmem DestOut", 32'(DestOut), 32'd9);
        check("nonmem WB_ENOut", 32'(WB_ENOut), 32'd1);
        check("nonmem MEM_R_ENOut", 32'(MEM_R_ENOut), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nonmem ready", 32'(ready), 32'd1);
            check("nonmem bus_en", 32'(bus_en), 32'd0);
        end
        @(posedge clk);
        #1;

        access("read1032", 1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 6'd2, 32'd0, 32'hDEADBEEF);
        access("write1024", 1'b0, 1'b1, 32'd1024, 32'h12345678, 32'h55555555, 6'd0,
               32'hDEADBEEF, 32'hDEADBEEF);
        access("rdwr1044", 1'b1, 1'b1, 32'd1044, 32'hA5A5A5A5, 32'h77777777, 6'd5,
               32'hDEADBEEF, 32'hDEADBEEF);
        access("b2b1028", 1'b1, 1'b0, 32'd1028, 32'd0, 32'h000000A1, 6'd1, 32'hDEADBEEF, 32'h000000A1);
        access("b2b1036", 1'b1, 1'b0, 32'd1036, 32'd0, 32'h000000B3, 6'd3, 32'h000000A1, 32'h000000B3);

`ifdef MEM_ADDR_CHECK_EN
        drive(1'b1, 1'b1, 1'b0, 32'd1026, 32'd0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fault mem_err", 32'(mem_err), 32'd1);
            check("fault ready", 32'(ready), 32'd1);
            check("fault bus_en", 32'(bus_en), 32'd0);
            check("fault Mem_ResOut", Mem_ResOut, 32'h000000B3);
        end
        @(posedge clk);
        #1;
`endif

        // Reset during the second ACCESS cycle
        drive(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd4);
        bus_rdata = 32'h13579BDF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        check("midrst bus_en before", 32'(bus_en), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst bus_en", 32'(bus_en), 32'd0);
        check("midrst bus_we", 32'(bus_we), 32'd0);
        check("midrst Mem_ResOut", Mem_ResOut, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("postrst ready", 32'(ready), 32'd1);
            check("postrst bus_en", 32'(bus_en), 32'd0);
            check("postrst Mem_ResOut", Mem_ResOut, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
